// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, optional skid entry,
// flush to a bubble control value and a sticky halt marker.
module pipe_stage_reg #(
   parameter int unsigned            DATA_W         = 32,
   parameter int unsigned            CTRL_W         = 8,
   parameter logic [CTRL_W-1:0]      CTRL_FLUSH_VAL = '0,
   parameter bit                     SKID_EN        = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              enable,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic              halt,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic              halt;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   localparam entry_t EntryReset = '{halt: 1'b0, ctrl: CTRL_FLUSH_VAL, data: '0};

   logic [1:0] occ_q, occ_d;
   entry_t     head_q, head_d;
   entry_t     skid_q, skid_d;
   logic       halt_q, halt_d;
   entry_t     in_entry;
   logic       push, pop;

   assign in_entry = '{halt: in_halt, ctrl: in_ctrl, data: in_data};

   always_comb begin
      out_valid = enable & (occ_q != 2'd0);
      if (SKID_EN) begin
         in_ready = enable & ~halt_q & ~flush & (occ_q != 2'd2);
      end else begin
         in_ready = enable & ~halt_q & ~flush & ((occ_q == 2'd0) | out_ready);
      end
      push = in_valid & in_ready;
      pop  = out_valid & out_ready;
   end

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      skid_d = skid_q;
      // Halt latches off the visible head regardless of downstream readiness.
      halt_d = halt_q | (out_valid & head_q.halt);
      if (flush) begin
         occ_d = 2'd0;
      end else if (enable) begin
         case (occ_q)
            2'd0: begin
               if (push) begin
                  head_d = in_entry;
                  occ_d  = 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_d = in_entry;
               end else if (push) begin
                  skid_d = in_entry;
                  occ_d  = 2'd2;
               end else if (pop) begin
                  occ_d = 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  head_d = skid_q;
                  if (push) begin
                     skid_d = in_entry;
                  end else begin
                     occ_d = 2'd1;
                  end
               end
            end
            default: occ_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         occ_q  <= 2'd0;
         head_q <= EntryReset;
         skid_q <= EntryReset;
         halt_q <= 1'b0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         skid_q <= skid_d;
         halt_q <= halt_d;
      end
   end

   // An empty stage presents the bubble control so no stale write enable leaks out.
   assign out_ctrl  = (occ_q == 2'd0) ? CTRL_FLUSH_VAL : head_q.ctrl;
   assign out_data  = head_q.data;
   assign halt      = halt_q;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a single-entry instance share inputs and
// are each checked against a FIFO reference model, plus directed tables and sequences.
module tb_pipe_stage_reg;

   logic        CLK = 1'b0;
   logic        RST;
   logic        enable, flush, in_valid, in_halt, out_ready;
   logic [7:0]  in_ctrl;
   logic [31:0] in_data;

   logic        ir   [2];
   logic        ov   [2];
   logic        hl   [2];
   logic [7:0]  oc   [2];
   logic [31:0] od   [2];
   logic [1:0]  occ  [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CTRL_FLUSH_VAL(8'h00), .SKID_EN(1'b1)) u_skid (
      .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl), .in_data(in_data),
      .in_halt(in_halt), .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]),
      .out_data(od[0]), .halt(hl[0]), .occupancy(occ[0])
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CTRL_FLUSH_VAL(8'hA0), .SKID_EN(1'b0)) u_ns (
      .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl), .in_data(in_data),
      .in_halt(in_halt), .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]),
      .out_data(od[1]), .halt(hl[1]), .occupancy(occ[1])
   );

   // Reference model: a bounded FIFO per instance.
   typedef struct {
      logic [7:0]  ctrl;
      logic [31:0] data;
      logic        halt;
   } ment_t;

   ment_t       mq    [2][2];
   int          msz   [2];
   logic        mhalt [2];
   logic [31:0] mlast [2];

   function automatic logic [7:0] fv(input int m);
      return (m == 0) ? 8'h00 : 8'hA0;
   endfunction

   function automatic logic m_ov(input int m);
      return enable && (msz[m] != 0);
   endfunction

   function automatic logic m_ir(input int m);
      logic room;
      room = (m == 0) ? (msz[m] < 2) : ((msz[m] == 0) || out_ready);
      return enable && !mhalt[m] && !flush && room;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         msz[m] = 0; mhalt[m] = 1'b0; mlast[m] = 32'h0;
      end
   endtask

   task automatic model_update();
      for (int m = 0; m < 2; m++) begin
         logic push, pop;
         push = in_valid && m_ir(m);
         pop  = m_ov(m) && out_ready;
         if (m_ov(m) && mq[m][0].halt) mhalt[m] = 1'b1;
         if (flush) begin
            msz[m] = 0;
         end else begin
            if (pop) begin
               mq[m][0] = mq[m][1];
               msz[m]--;
            end
            if (push) begin
               mq[m][msz[m]] = '{ctrl: in_ctrl, data: in_data, halt: in_halt};
               msz[m]++;
            end
         end
         if (msz[m] != 0) mlast[m] = mq[m][0].data;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("m%0d out_valid", m), 32'(ov[m]), 32'(m_ov(m)));
         chk($sformatf("m%0d in_ready", m), 32'(ir[m]), 32'(m_ir(m)));
         chk($sformatf("m%0d occupancy", m), 32'(occ[m]), 32'(msz[m]));
         chk($sformatf("m%0d halt", m), 32'(hl[m]), 32'(mhalt[m]));
         chk($sformatf("m%0d out_ctrl", m), 32'(oc[m]),
             32'((msz[m] != 0) ? mq[m][0].ctrl : fv(m)));
         chk($sformatf("m%0d out_data", m), od[m], (msz[m] != 0) ? mq[m][0].data : mlast[m]);
      end
   endtask

   // Called just after a rising edge: settle away from the edge and check.
   task automatic settle();
      #4;
      check_model();
   endtask

   task automatic advance();
      if (!RST) model_update();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input bit iv, input bit ordy, input bit en, input bit fl, input bit h,
                        input logic [31:0] d, input logic [7:0] c);
      in_valid = iv; out_ready = ordy; enable = en; flush = fl; in_halt = h;
      in_data = d; in_ctrl = c;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rst m%0d occupancy", m), 32'(occ[m]), 32'd0);
         chk($sformatf("rst m%0d halt", m), 32'(hl[m]), 32'd0);
         chk($sformatf("rst m%0d out_valid", m), 32'(ov[m]), 32'd0);
         chk($sformatf("rst m%0d out_data", m), od[m], 32'h0);
         chk($sformatf("rst m%0d out_ctrl", m), 32'(oc[m]), 32'(fv(m)));
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   typedef struct {
      bit          iv, ordy, en, fl, h;
      logic [31:0] d;
      logic [7:0]  c;
      bit          ov, ir;
      logic [1:0]  occ;
      logic [31:0] od;
      logic [7:0]  oc;
      bit          hl;
   } vec_t;

   vec_t tbl [22];

   initial begin
      // iv ordy en fl h  data  ctrl | ov ir occ out_data ctrl halt  (skid instance)
      tbl[0]  = '{1, 1, 1, 0, 0, 32'h1234, 8'h05, 0, 1, 0, 32'h0,    8'h00, 0};
      tbl[1]  = '{0, 1, 1, 0, 0, 32'h0,    8'h00, 1, 1, 1, 32'h1234, 8'h05, 0};
      tbl[2]  = '{0, 0, 1, 0, 0, 32'h0,    8'h00, 0, 1, 0, 32'h1234, 8'h00, 0};
      tbl[3]  = '{1, 0, 1, 0, 0, 32'h10,   8'h11, 0, 1, 0, 32'h1234, 8'h00, 0};
      tbl[4]  = '{1, 0, 1, 0, 0, 32'h20,   8'h22, 1, 1, 1, 32'h10,   8'h11, 0};
      tbl[5]  = '{0, 0, 1, 0, 0, 32'h0,    8'h00, 1, 0, 2, 32'h10,   8'h11, 0};
      tbl[6]  = '{0, 1, 1, 0, 0, 32'h0,    8'h00, 1, 0, 2, 32'h10,   8'h11, 0};
      tbl[7]  = '{0, 1, 1, 0, 0, 32'h0,    8'h00, 1, 1, 1, 32'h20,   8'h22, 0};
      tbl[8]  = '{0, 1, 1, 0, 0, 32'h0,    8'h00, 0, 1, 0, 32'h20,   8'h00, 0};
      tbl[9]  = '{1, 0, 1, 0, 0, 32'h30,   8'h33, 0, 1, 0, 32'h20,   8'h00, 0};
      tbl[10] = '{1, 0, 1, 0, 0, 32'h40,   8'h44, 1, 1, 1, 32'h30,   8'h33, 0};
      tbl[11] = '{1, 1, 0, 0, 0, 32'h50,   8'h55, 0, 0, 2, 32'h30,   8'h33, 0};
      tbl[12] = '{1, 1, 0, 0, 0, 32'h50,   8'h55, 0, 0, 2, 32'h30,   8'h33, 0};
      tbl[13] = '{1, 1, 0, 0, 0, 32'h50,   8'h55, 0, 0, 2, 32'h30,   8'h33, 0};
      tbl[14] = '{1, 1, 0, 1, 0, 32'h50,   8'h55, 0, 0, 2, 32'h30,   8'h33, 0};
      tbl[15] = '{0, 0, 1, 0, 0, 32'h0,    8'h00, 0, 1, 0, 32'h30,   8'h00, 0};
      tbl[16] = '{1, 0, 1, 0, 1, 32'h60,   8'h66, 0, 1, 0, 32'h30,   8'h00, 0};
      tbl[17] = '{1, 0, 1, 0, 0, 32'h70,   8'h77, 1, 1, 1, 32'h60,   8'h66, 0};
      tbl[18] = '{1, 0, 1, 0, 0, 32'h80,   8'h88, 1, 0, 2, 32'h60,   8'h66, 1};
      tbl[19] = '{1, 1, 1, 0, 0, 32'h80,   8'h88, 1, 0, 2, 32'h60,   8'h66, 1};
      tbl[20] = '{1, 1, 1, 0, 0, 32'h80,   8'h88, 1, 0, 1, 32'h70,   8'h77, 1};
      tbl[21] = '{1, 1, 1, 0, 0, 32'h80,   8'h88, 0, 0, 0, 32'h70,   8'h00, 1};

      drive(0, 0, 1, 0, 0, 32'h0, 8'h0);
      RST = 1'b0;
      #1;
      do_reset();

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].iv, tbl[i].ordy, tbl[i].en, tbl[i].fl, tbl[i].h, tbl[i].d, tbl[i].c);
         settle();
         chk($sformatf("tbl%0d out_valid", i), 32'(ov[0]), 32'(tbl[i].ov));
         chk($sformatf("tbl%0d in_ready", i), 32'(ir[0]), 32'(tbl[i].ir));
         chk($sformatf("tbl%0d occupancy", i), 32'(occ[0]), 32'(tbl[i].occ));
         chk($sformatf("tbl%0d out_data", i), od[0], tbl[i].od);
         chk($sformatf("tbl%0d out_ctrl", i), 32'(oc[0]), 32'(tbl[i].oc));
         chk($sformatf("tbl%0d halt", i), 32'(hl[0]), 32'(tbl[i].hl));
         advance();
      end

      // Halt is cleared only by reset.
      drive(0, 0, 1, 0, 0, 32'h0, 8'h0);
      do_reset();

      // Single-entry instance streams at full rate.
      for (int k = 1; k <= 4; k++) begin
         drive(k <= 3, 1, 1, 0, 0, 32'(k), 8'(k));
         settle();
         if (k <= 3) chk($sformatf("ns stream%0d in_ready", k), 32'(ir[1]), 32'd1);
         if (k >= 2) begin
            chk($sformatf("ns stream%0d out_valid", k), 32'(ov[1]), 32'd1);
            chk($sformatf("ns stream%0d out_data", k), od[1], 32'(k - 1));
         end
         advance();
      end
      drive(0, 1, 1, 0, 0, 32'h0, 8'h0);
      settle();
      advance();

      // Asynchronous reset mid-cycle with the skid instance full.
      drive(1, 0, 1, 0, 0, 32'hA, 8'h0A);
      settle();
      advance();
      drive(1, 0, 1, 0, 0, 32'hB, 8'h0B);
      settle();
      advance();
      drive(0, 0, 1, 0, 0, 32'h0, 8'h0);
      #1;
      chk("async pre occupancy", 32'(occ[0]), 32'd2);
      #1;
      do_reset();

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 39) == 0), $urandom, 8'($urandom));
         if ($urandom_range(0, 119) == 0) begin
            RST = 1'b1;
            model_reset();
         end
         settle();
         advance();
         RST = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
